// File: rtl/program_mem_pkg.sv
// Shared constants and loader state encoding for the field-loadable program memory.
package program_mem_pkg;

    localparam int          DEF_DATA_W   = 16;
    localparam int          DEF_ADDR_W   = 4;
    localparam logic [15:0] DEF_NOP_WORD = 16'h0200;

    typedef enum logic {
        LD_IDLE = 1'b0,
        LD_LOAD = 1'b1
    } ld_state_t;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-serial loader: assembles MSB-first bytes into words and emits a memory write port.
// Latency: a word write is presented in the same cycle as its last (or prog_last) byte.
// Backpressure: prog_ready is high only in LOAD; bytes offered in IDLE are dropped.
module prog_loader
    import program_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_start,
    input  logic              prog_valid,
    input  logic [7:0]        prog_data,
    input  logic              prog_last,
    output logic              prog_ready,
    output logic              prog_busy,
    output logic              prog_done,
    output logic [ADDR_W:0]   prog_count,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);

    localparam int         BYTES     = bytes_per_word(DATA_W);
    localparam logic [2:0] LAST_BYTE = 3'(BYTES - 1);

    ld_state_t         state;
    ld_state_t         state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [2:0]        byte_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_nxt;
    logic [5:0]        pad_sh;
    logic              xfer;
    logic              word_end;
    logic              load_end;

    assign shift_nxt = (shift_reg << 8) | DATA_W'(prog_data);
    assign word_end  = (byte_cnt == LAST_BYTE);
    // Byte positions still missing in the word, as a bit shift; zero on a full word.
    assign pad_sh    = {LAST_BYTE - byte_cnt, 3'b000};
    assign load_end  = prog_last | (word_end & (&wr_ptr));

    assign we    = xfer & (word_end | prog_last);
    assign waddr = wr_ptr;
    assign wdata = shift_nxt << pad_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        prog_ready = 1'b0;
        prog_busy  = 1'b0;
        xfer       = 1'b0;
        case (state)
            LD_IDLE: begin
                if (prog_start) begin
                    state_nxt = LD_LOAD;
                end
            end
            LD_LOAD: begin
                prog_ready = 1'b1;
                prog_busy  = 1'b1;
                // A restart takes priority and throws away any byte offered alongside it.
                xfer       = prog_valid & ~prog_start;
                if (xfer && load_end) begin
                    state_nxt = LD_IDLE;
                end
            end
            default: begin
                state_nxt = LD_IDLE;
            end
        endcase
        if (prog_start) begin
            state_nxt = LD_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            byte_cnt   <= '0;
            shift_reg  <= '0;
            prog_count <= '0;
            prog_done  <= 1'b0;
        end else begin
            prog_done <= 1'b0;
            if (prog_start) begin
                wr_ptr     <= '0;
                byte_cnt   <= '0;
                shift_reg  <= '0;
                prog_count <= '0;
            end else if (xfer) begin
                prog_done <= load_end;
                if (we) begin
                    wr_ptr     <= wr_ptr + ADDR_W'(1);
                    prog_count <= prog_count + (ADDR_W + 1)'(1);
                    byte_cnt   <= '0;
                    shift_reg  <= '0;
                end else begin
                    byte_cnt  <= byte_cnt + 3'd1;
                    shift_reg <= shift_nxt;
                end
            end
        end
    end

endmodule

// File: rtl/program_mem.sv
// Instruction memory with a registered fetch port and a run-time byte loader.
// Latency: fetch data and inst_valid appear one edge after an accepted fetch_en.
// Backpressure: fetch_stall flags fetches refused while the loader is busy.
module program_mem
    import program_mem_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEF_NOP_WORD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instruction,
    output logic              inst_valid,
    output logic              fetch_stall,
    input  logic              prog_start,
    input  logic              prog_valid,
    input  logic [7:0]        prog_data,
    input  logic              prog_last,
    output logic              prog_ready,
    output logic              prog_busy,
    output logic              prog_done,
    output logic [ADDR_W:0]   prog_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    // Contents survive reset; only the power-up image is fixed.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

    prog_loader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .prog_start (prog_start),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_last  (prog_last),
        .prog_ready (prog_ready),
        .prog_busy  (prog_busy),
        .prog_done  (prog_done),
        .prog_count (prog_count),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata)
    );

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign fetch_stall = fetch_en & prog_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction <= NOP_WORD;
            inst_valid  <= 1'b0;
        end else if (prog_busy) begin
            instruction <= NOP_WORD;
            inst_valid  <= 1'b0;
        end else if (fetch_en) begin
            instruction <= mem[fetch_addr];
            inst_valid  <= 1'b1;
        end else begin
            inst_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_program_mem.sv
// Randomised bench for program_mem against an image-level reference model.
module tb_program_mem;

    localparam int          DEPTH = 16;
    localparam logic [15:0] NOP   = 16'h0200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic [3:0]  fetch_addr = '0;
    logic [15:0] instruction;
    logic        inst_valid;
    logic        fetch_stall;
    logic        prog_start = 1'b0;
    logic        prog_valid = 1'b0;
    logic [7:0]  prog_data = '0;
    logic        prog_last = 1'b0;
    logic        prog_ready;
    logic        prog_busy;
    logic        prog_done;
    logic [4:0]  prog_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_mem [DEPTH];
    int          model_count;
    logic [7:0]  img [$];

    program_mem dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .instruction (instruction),
        .inst_valid  (inst_valid),
        .fetch_stall (fetch_stall),
        .prog_start  (prog_start),
        .prog_valid  (prog_valid),
        .prog_data   (prog_data),
        .prog_last   (prog_last),
        .prog_ready  (prog_ready),
        .prog_busy   (prog_busy),
        .prog_done   (prog_done),
        .prog_count  (prog_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [3:0] a);
        fetch_en   = 1'b1;
        fetch_addr = a;
        tick();
        fetch_en   = 1'b0;
    endtask

    task automatic start_load();
        prog_start = 1'b1;
        tick();
        prog_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        prog_valid = 1'b1;
        prog_data  = d;
        prog_last  = last;
        tick();
        prog_valid = 1'b0;
        prog_last  = 1'b0;
    endtask

    // Image-level model: bytes pair up MSB-first into words; a final odd byte is
    // zero-padded only when terminated by prog_last; at most DEPTH words are kept.
    task automatic model_load(input bit use_last);
        int n;
        int words;
        n = img.size();
        words = use_last ? (n + 1) / 2 : n / 2;
        if (words > DEPTH) words = DEPTH;
        for (int w = 0; w < words; w++) begin
            model_mem[w] = {img[2*w], (2*w + 1 < n) ? img[2*w+1] : 8'h00};
        end
        model_count = words;
    endtask

    task automatic test_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
        model_count = 0;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (instruction !== NOP) begin errors++; $display("FAIL reset_instruction got %h exp %h", instruction, NOP); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid); end
        checks++; if ({prog_ready, prog_busy, prog_done} !== 3'b000) begin errors++; $display("FAIL reset_prog_flags got %b exp 000", {prog_ready, prog_busy, prog_done}); end
        checks++; if (prog_count !== 5'd0) begin errors++; $display("FAIL reset_prog_count got %0d exp 0", prog_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch_all();
        for (int a = 0; a < DEPTH; a++) begin
            do_fetch(4'(a));
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid a=%0d got %b exp 1", a, inst_valid); end
            checks++; if (instruction !== model_mem[a]) begin errors++; $display("FAIL fetch_data a=%0d got %h exp %h", a, instruction, model_mem[a]); end
        end
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fetch_idle_valid got %b exp 0", inst_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a;
        fetch_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = 4'($urandom_range(0, DEPTH - 1));
            fetch_addr = a;
            tick();
            checks++; if (inst_valid !== 1'b1 || instruction !== model_mem[a]) begin errors++; $display("FAIL b2b a=%0d got %b/%h exp 1/%h", a, inst_valid, instruction, model_mem[a]); end
        end
        fetch_en = 1'b0;
        tick();
    endtask

    task automatic test_counting_load();
        img.delete();
        for (int k = 1; k <= DEPTH; k++) begin img.push_back(8'h00); img.push_back(8'(k)); end
        start_load();
        checks++; if ({prog_busy, prog_ready} !== 2'b11 || prog_count !== 5'd0) begin errors++; $display("FAIL start_state got busy/ready %b count %0d exp 11/0", {prog_busy, prog_ready}, prog_count); end
        for (int i = 0; i < img.size(); i++) begin
            checks++; if (prog_ready !== 1'b1) begin errors++; $display("FAIL count_ready i=%0d got %b exp 1", i, prog_ready); end
            send_byte(img[i], i == img.size() - 1);
            checks++; if (prog_done !== (i == img.size() - 1)) begin errors++; $display("FAIL count_done i=%0d got %b exp %b", i, prog_done, i == img.size() - 1); end
        end
        model_load(1'b1);
        checks++; if (prog_count !== 5'd16 || prog_ready !== 1'b0) begin errors++; $display("FAIL count_end got count %0d ready %b exp 16/0", prog_count, prog_ready); end
        do_fetch(4'd5);
        checks++; if (prog_done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b exp 0", prog_done); end
        checks++; if (instruction !== 16'h0006 || instruction !== model_mem[5]) begin errors++; $display("FAIL count_word5 got %h exp 0006", instruction); end
    endtask

    task automatic test_partial_word();
        img.delete();
        img.push_back(8'h12); img.push_back(8'h34); img.push_back(8'h56);
        start_load();
        for (int i = 0; i < 3; i++) send_byte(img[i], i == 2);
        model_load(1'b1);
        checks++; if (prog_done !== 1'b1 || prog_count !== 5'(model_count)) begin errors++; $display("FAIL partial_end got done %b count %0d exp 1/%0d", prog_done, prog_count, model_count); end
        for (int a = 0; a < DEPTH; a++) begin
            do_fetch(4'(a));
            checks++; if (instruction !== model_mem[a]) begin errors++; $display("FAIL partial_word a=%0d got %h exp %h", a, instruction, model_mem[a]); end
        end
        do_fetch(4'd1);
        checks++; if (instruction !== 16'h5600) begin errors++; $display("FAIL partial_pad got %h exp 5600", instruction); end
    endtask

    task automatic test_stall_during_load();
        logic [3:0] fa;
        int n;
        n = $urandom_range(1, 32);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(8'($urandom));
        fa = 4'($urandom_range(0, (n + 1) / 2 - 1));
        fetch_en = 1'b1;
        fetch_addr = fa;
        start_load();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL stall_flag i=%0d got %b exp 1", i, fetch_stall); end
            send_byte(img[i], i == n - 1);
            checks++; if (inst_valid !== 1'b0 || instruction !== NOP) begin errors++; $display("FAIL stall_output i=%0d got %b/%h exp 0/%h", i, inst_valid, instruction, NOP); end
        end
        model_load(1'b1);
        checks++; if (prog_done !== 1'b1 || fetch_stall !== 1'b0) begin errors++; $display("FAIL stall_end got done %b stall %b exp 1/0", prog_done, fetch_stall); end
        tick();
        fetch_en = 1'b0;
        checks++; if (inst_valid !== 1'b1 || instruction !== model_mem[fa]) begin errors++; $display("FAIL stall_first_fetch a=%0d got %b/%h exp 1/%h", fa, inst_valid, instruction, model_mem[fa]); end
    endtask

    task automatic test_restart();
        img.delete();
        for (int i = 0; i < 3; i++) img.push_back(8'($urandom));
        start_load();
        for (int i = 0; i < 3; i++) send_byte(img[i], 1'b0);
        model_load(1'b0);
        start_load();
        checks++; if (prog_busy !== 1'b1 || prog_count !== 5'd0) begin errors++; $display("FAIL restart_state got busy %b count %0d exp 1/0", prog_busy, prog_count); end
        img.delete();
        for (int i = 0; i < 2; i++) img.push_back(8'($urandom));
        for (int i = 0; i < 2; i++) send_byte(img[i], i == 1);
        model_load(1'b1);
        checks++; if (prog_count !== 5'd1) begin errors++; $display("FAIL restart_count got %0d exp 1", prog_count); end
        for (int a = 0; a < 2; a++) begin
            do_fetch(4'(a));
            checks++; if (instruction !== model_mem[a]) begin errors++; $display("FAIL restart_word a=%0d got %h exp %h", a, instruction, model_mem[a]); end
        end
    endtask

    task automatic test_reset_midload();
        start_load();
        send_byte(8'($urandom), 1'b0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        checks++; if ({prog_busy, prog_ready, prog_done} !== 3'b000 || prog_count !== 5'd0) begin errors++; $display("FAIL midreset_state got %b count %0d exp 000/0", {prog_busy, prog_ready, prog_done}, prog_count); end
        tick();
        send_byte(8'hA5, 1'b1);
        checks++; if (prog_busy !== 1'b0 || prog_count !== 5'd0 || prog_done !== 1'b0) begin errors++; $display("FAIL idle_byte got busy %b count %0d done %b exp 0/0/0", prog_busy, prog_count, prog_done); end
        do_fetch(4'd0);
        checks++; if (instruction !== model_mem[0]) begin errors++; $display("FAIL midreset_word0 got %h exp %h", instruction, model_mem[0]); end
    endtask

    task automatic test_full_no_last();
        img.delete();
        for (int i = 0; i < 2 * DEPTH; i++) img.push_back(8'($urandom));
        start_load();
        for (int i = 0; i < 2 * DEPTH; i++) begin
            if ($urandom_range(0, 4) == 0) tick();
            send_byte(img[i], 1'b0);
            checks++; if (prog_done !== (i == 2 * DEPTH - 1)) begin errors++; $display("FAIL full_done i=%0d got %b exp %b", i, prog_done, i == 2 * DEPTH - 1); end
        end
        model_load(1'b0);
        checks++; if (prog_count !== 5'd16 || prog_ready !== 1'b0 || prog_busy !== 1'b0) begin errors++; $display("FAIL full_end got count %0d ready %b busy %b exp 16/0/0", prog_count, prog_ready, prog_busy); end
        send_byte(~img[0], 1'b0);
        checks++; if (prog_count !== 5'd16 || prog_done !== 1'b0) begin errors++; $display("FAIL extra_byte got count %0d done %b exp 16/0", prog_count, prog_done); end
        for (int a = 0; a < DEPTH; a++) begin
            do_fetch(4'(a));
            checks++; if (instruction !== model_mem[a]) begin errors++; $display("FAIL full_word a=%0d got %h exp %h", a, instruction, model_mem[a]); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_all();
        test_back_to_back();
        test_counting_load();
        test_partial_word();
        for (int r = 0; r < 4; r++) test_stall_during_load();
        test_restart();
        test_reset_midload();
        test_full_no_last();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
